edge_event_counter: RTL and testbench

- Parametrised multi-channel event counter; successor to the two-input clocked application block.
- Each asynchronous input channel is synchronised, then edge-detected under a selectable mode and counted in its own counter.
- Selectable wrap or saturate; per-channel sticky overflow flags.
- A selected channel's count drives the num output. A registered threshold compare drives out.
- Sits between raw board inputs (switches/buttons) and display/LED logic.

---
 rtl/edge_event_counter.sv | 127 ++++++++++++
 tb/tb_edge_event_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_counter.sv
// rtl/edge_event_counter.sv - multi-channel synchronised edge event counter
// Per-channel synchroniser, mode-selected edge detect, wrap/saturate counters, threshold compare.
module edge_event_counter #(
  parameter  int CH          = 2,
  parameter  int CNT_W       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    in,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] num,
  output logic             out,
  output logic [CH-1:0]    ovf
);

  localparam int PRIME_N = SYNC_STAGES + 1;
  localparam int PRIME_W = $clog2(PRIME_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CH-1:0][SYNC_STAGES-1:0] r_sync;
  logic [CH-1:0]                  r_prev;
  logic [CH-1:0][CNT_W-1:0]       r_cnt;
  logic [CH-1:0]                  r_ovf;
  logic                           r_out;
  logic [PRIME_W-1:0]             r_prime;

  logic [CH-1:0]    w_s;
  logic [CH-1:0]    w_rise;
  logic [CH-1:0]    w_fall;
  logic [CH-1:0]    w_edge;
  logic             w_primed;
  logic [CNT_W-1:0] w_num;

  // Until the synchroniser and previous-sample registers hold real data, any edge is an artefact.
  assign w_primed = (r_prime == PRIME_W'(PRIME_N));

  always_comb begin
    w_s = '0;
    for (int i = 0; i < CH; i++) begin
      w_s[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;

  always_comb begin
    w_edge = '0;
    case (mode)
      2'b00:   w_edge = w_rise;
      2'b01:   w_edge = w_fall;
      2'b10:   w_edge = w_rise | w_fall;
      default: w_edge = '0;
    endcase
    if (!w_primed) begin
      w_edge = '0;
    end
  end

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    w_num = r_cnt[0];
    for (int i = 0; i < CH; i++) begin
      if (sel == SEL_W'(i)) begin
        w_num = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prev  <= '0;
      r_prime <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], in[i]};
      end
      r_prev <= w_s;
      if (!w_primed) begin
        r_prime <= r_prime + PRIME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_edge[i]) begin
          if (r_cnt[i] != CNT_MAX) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end else begin
            r_ovf[i] <= 1'b1;
            if (!sat_en) begin
              r_cnt[i] <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 1'b0;
    end else begin
      r_out <= (w_num >= thresh);
    end
  end

  assign num = w_num;
  assign out = r_out;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_edge_event_counter.sv
// tb/tb_edge_event_counter.sv - directed self-checking bench for edge_event_counter
// CH=2, CNT_W=4, SYNC_STAGES=2; inputs driven and outputs sampled 1ns after rising clk.
module tb_edge_event_counter;

  logic       clk;
  logic       rst_n;
  logic [1:0] in;
  logic [1:0] mode;
  logic       sat_en;
  logic       clr;
  logic [0:0] sel;
  logic [3:0] thresh;
  logic [3:0] num;
  logic       out;
  logic [1:0] ovf;

  int errors;
  int checks;

  edge_event_counter #(.CH(2), .CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .mode   (mode),
    .sat_en (sat_en),
    .clr    (clr),
    .sel    (sel),
    .thresh (thresh),
    .num    (num),
    .out    (out),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle_ch1(input int n);
    for (int i = 0; i < n; i++) begin
      in[1] = ~in[1];
      tick(4);
    end
  endtask

  task automatic pulse_ch0(input int n, input int w);
    for (int i = 0; i < n; i++) begin
      in[0] = 1'b1;
      tick(w);
      in[0] = 1'b0;
      tick(w);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", num); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%0b exp=0", out); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_rise_latency;
    mode = 2'b00; sel = 1'b0;
    pulse_ch0(2, 5);
    in[0] = 1'b1;
    tick(1);
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL lat_k got=%0d exp=2", num); end
    tick(1);
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL lat_k1 got=%0d exp=2", num); end
    tick(1);
    checks++; if (num !== 4'd3) begin errors++; $display("FAIL lat_k2 got=%0d exp=3", num); end
    in[0] = 1'b0;
    tick(5);
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL rise_ovf got=%b exp=00", ovf); end
    sel = 1'b1; #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL rise_ch1 got=%0d exp=0", num); end
    sel = 1'b0;
  endtask

  task automatic test_wrap;
    clr = 1'b1; tick(1); clr = 1'b0;
    mode = 2'b10; sat_en = 1'b0; sel = 1'b1;
    toggle_ch1(15);
    checks++; if (num !== 4'd15) begin errors++; $display("FAIL wrap_15 got=%0d exp=15", num); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL wrap_ovf15 got=%b exp=00", ovf); end
    toggle_ch1(1);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL wrap_16 got=%0d exp=0", num); end
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL wrap_ovf16 got=%b exp=10", ovf); end
    toggle_ch1(4);
    checks++; if (num !== 4'd4) begin errors++; $display("FAIL wrap_20 got=%0d exp=4", num); end
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL wrap_ovf20 got=%b exp=10", ovf); end
    sel = 1'b0; #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL wrap_ch0 got=%0d exp=0", num); end
  endtask

  task automatic test_saturate;
    clr = 1'b1; tick(1); clr = 1'b0;
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL sat_clr_ovf got=%b exp=00", ovf); end
    sat_en = 1'b1; sel = 1'b1;
    toggle_ch1(20);
    checks++; if (num !== 4'd15) begin errors++; $display("FAIL sat_20 got=%0d exp=15", num); end
    checks++; if (ovf !== 2'b10) begin errors++; $display("FAIL sat_ovf got=%b exp=10", ovf); end
    toggle_ch1(4);
    checks++; if (num !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", num); end
    sat_en = 1'b0;
  endtask

  task automatic test_thresh_clr;
    clr = 1'b1; tick(1); clr = 1'b0;
    mode = 2'b00; sel = 1'b0; thresh = 4'd3;
    pulse_ch0(2, 4);
    in[0] = 1'b1;
    tick(3);
    checks++; if (num !== 4'd3) begin errors++; $display("FAIL thr_num got=%0d exp=3", num); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL thr_out_early got=%0b exp=0", out); end
    tick(1);
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL thr_out got=%0b exp=1", out); end
    in[0] = 1'b0;
    tick(4);
    in[0] = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL clr_num got=%0d exp=0", num); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL clr_out_lag got=%0b exp=1", out); end
    tick(1);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL clr_out got=%0b exp=0", out); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL clr_ovf got=%b exp=00", ovf); end
    tick(4);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL clr_drop got=%0d exp=0", num); end
    in[0] = 1'b0;
    tick(4);
  endtask

  task automatic test_held_high;
    in = 2'b11; mode = 2'b00; thresh = 4'd0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    sel = 1'b0; #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL held_ch0 got=%0d exp=0", num); end
    sel = 1'b1; #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL held_ch1 got=%0d exp=0", num); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL thresh0_out got=%0b exp=1", out); end
    mode = 2'b01; tick(5);
    mode = 2'b10; tick(5);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL mode_sw_ch1 got=%0d exp=0", num); end
    sel = 1'b0; #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL mode_sw_ch0 got=%0d exp=0", num); end
  endtask

  task automatic test_async_reset;
    in = 2'b00; mode = 2'b00; sel = 1'b0; thresh = 4'd3;
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(5);
    pulse_ch0(7, 2);
    tick(3);
    checks++; if (num !== 4'd7) begin errors++; $display("FAIL ar_pre_num got=%0d exp=7", num); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL ar_pre_out got=%0b exp=1", out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL ar_num got=%0d exp=0", num); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL ar_out got=%0b exp=0", out); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL ar_ovf got=%b exp=00", ovf); end
    tick(2);
    rst_n = 1'b1;
    in[0] = 1'b1;
    tick(10);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL ar_prime got=%0d exp=0", num); end
    in[0] = 1'b0;
    tick(3);
    in[0] = 1'b1;
    tick(3);
    checks++; if (num !== 4'd1) begin errors++; $display("FAIL ar_after got=%0d exp=1", num); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; in = 2'b00; mode = 2'b00; sat_en = 1'b0; clr = 1'b0;
    sel = 1'b0; thresh = 4'd15;
    test_reset;
    test_rise_latency;
    test_wrap;
    test_saturate;
    test_thresh_clr;
    test_held_high;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
